id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS redirect pipeline; sits directly downstream of the ID-stage hazard/forwarding detector.
- Latches decoded ID fields, register-file operands and the detector's forwarding-match flags into EX.
- Turns the detector's stall (and the EX-stage branch flush) into a bubble.
- Detects the halt syscall and freezes the stage into a halted state.

Parameters:
- DW, 32, data/PC/immediate width.
- HALT_CODE, 10, value of id_rd1 ($v0) that makes a syscall a halt.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global advance enable; 0 freezes the register
- stall  in  1  load-use stall from the hazard detector
- flush  in  1  branch/jump taken in EX; kill the instruction in ID
- id_op, id_funct  in  6  decoded opcode / funct
- id_rs, id_rt, id_rd, id_shamt  in  5  register and shift fields
- id_pc, id_rd1, id_rd2, id_imm  in  DW  PC, rs/rt operands, extended immediate
- id_fwd  in  6  {ALUaeq, ALUbeq, MEMaeq, MEMbeq, rfd2alueq, rfd2dmeq} from the detector
- ex_op, ex_funct, ex_rs, ex_rt, ex_rd, ex_shamt, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_fwd  out  same widths  registered copies
- ex_valid  out  1  EX holds a real instruction, not a bubble
- ex_halt  out  1  stage is in HALT state

Behaviour:
- Reset (async, rst_n=0): every ex_* output = 0, ex_valid = 0, ex_halt = 0, state = RUN.
  - Op 0 / funct 0 / rd 0 is the canonical NOP (sll $0). The detector decodes it as destination 0, so it creates no hazard.
- Latency: one cycle; fields present on ID at edge N appear on EX after edge N.
- State RUN, per rising edge, priority order:
  1. en=0: hold all outputs and state.
  2. flush=1 or stall=1: load a bubble (all ex_* fields 0, ex_valid=0). flush and stall together produce one bubble, not two.
  3. Otherwise: load all id_* fields and set ex_valid=1.
- Halt detect: in RUN with en=1, stall=0, flush=0, id_op=0, id_funct=6'h0c and id_rd1==HALT_CODE:
  - the syscall is loaded normally (ex_valid=1);
  - state moves to HALT on the same edge;
  - ex_halt=1 from that edge.
- A syscall with id_rd1 != HALT_CODE passes as an ordinary instruction.
- A halting syscall that is stalled or flushed does not halt.
- State HALT:
  - en=1: every edge loads a bubble; id_* inputs, stall and flush are ignored. The syscall therefore stays in EX for exactly one cycle.
  - en=0: hold.
  - Leave only via rst_n=0.
- id_fwd is latched unmodified; bubbles clear it to 0, so EX/MEM forwarding muxes select the register-file path.
- No combinational path from inputs to outputs; all outputs come from flops.
- Reset asserted mid-stream clears immediately, without waiting for an edge. After release, the first edge with en=1 loads ID normally.

Optional Feature:
- Macro: IDEX_BUBBLE_CNT_EN.
- Defined:
  - adds output ex_bubble_cnt [15:0];
  - increments by 1 on each edge where a bubble is loaded because of stall or flush in RUN, with en=1;
  - HALT-state bubbles are not counted;
  - saturates at 16'hFFFF, no wrap;
  - async reset to 0;
  - held when en=0.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then load: rst_n low for 2 cycles, release, present add $3,$1,$2 (op 0, funct 0x20, rs 1, rt 2, rd 3, rd1 5, rd2 7) -> after 1 edge ex_funct=0x20, ex_rd=3, ex_rd1=5, ex_rd2=7, ex_valid=1.
- Load-use stall: stall=1 for one edge with id_fwd=6'b100000 -> ex_* all 0, ex_fwd=0, ex_valid=0. Next edge, stall=0 with the same ID -> instruction loaded with ex_fwd=6'b100000.
- Stall+flush together for one edge, then en=0 for 3 edges -> one bubble, then outputs frozen. With IDEX_BUBBLE_CNT_EN, ex_bubble_cnt=1.
- Halt: syscall (op 0, funct 0x0c) with id_rd1=10 -> ex_valid=1, ex_halt=1. Next 4 edges with a valid add on ID -> bubbles, ex_halt stays 1. rst_n=0 -> ex_halt=0 with no clock edge needed.
- Non-halt syscall with id_rd1=1 -> loaded with ex_valid=1, ex_halt remains 0. The same halting syscall with stall=1 -> bubble, no halt.
- With IDEX_BUBBLE_CNT_EN: 65540 consecutive stall edges -> ex_bubble_cnt=16'hFFFF (saturated). Async reset mid-run -> counter 0.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS redirect pipeline.
// Latches decoded ID fields, operands and forwarding-match flags into EX,
// converts stall/flush into bubbles and freezes into HALT on the halt syscall.
// Optional feature macro: IDEX_BUBBLE_CNT_EN (adds ex_bubble_cnt).
module id_ex_stage_reg #(
    parameter int unsigned DW        = 32,
    parameter int unsigned HALT_CODE = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          stall,
    input  logic          flush,
    input  logic [5:0]    id_op,
    input  logic [5:0]    id_funct,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [4:0]    id_shamt,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [5:0]    id_fwd,
    output logic [5:0]    ex_op,
    output logic [5:0]    ex_funct,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [4:0]    ex_shamt,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [5:0]    ex_fwd,
`ifdef IDEX_BUBBLE_CNT_EN
    output logic [15:0]   ex_bubble_cnt,
`endif
    output logic          ex_valid,
    output logic          ex_halt
);

    localparam int unsigned OPW   = 6;
    localparam int unsigned REGW  = 5;
    localparam int unsigned FWDW  = 6;
    localparam logic [OPW-1:0] OP_SPECIAL    = OPW'(0);
    localparam logic [OPW-1:0] FUNCT_SYSCALL = OPW'(12);

    // Payload carried from ID into EX; an all-zero payload is the canonical NOP.
    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [OPW-1:0]  funct;
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] rd;
        logic [REGW-1:0] shamt;
        logic [DW-1:0]   pc;
        logic [DW-1:0]   rd1;
        logic [DW-1:0]   rd2;
        logic [DW-1:0]   imm;
        logic [FWDW-1:0] fwd;
    } idex_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    idex_t  r_ex;
    idex_t  w_id;
    logic   r_valid;
    logic   w_load_id;
    logic   w_load_bubble;
    logic   w_is_halt;

    assign w_id = '{
        op:    id_op,
        funct: id_funct,
        rs:    id_rs,
        rt:    id_rt,
        rd:    id_rd,
        shamt: id_shamt,
        pc:    id_pc,
        rd1:   id_rd1,
        rd2:   id_rd2,
        imm:   id_imm,
        fwd:   id_fwd
    };

    // Halt syscall: special opcode, syscall funct, $v0 holding the halt code.
    assign w_is_halt = (id_op == OP_SPECIAL) && (id_funct == FUNCT_SYSCALL) &&
                       (id_rd1 == DW'(HALT_CODE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and load selection; stall and flush collapse into a single bubble.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_id     = 1'b0;
        w_load_bubble = 1'b0;
        if (en) begin
            case (r_state)
                S_RUN: begin
                    if (stall || flush) begin
                        w_load_bubble = 1'b1;
                    end else begin
                        w_load_id = 1'b1;
                        if (w_is_halt) begin
                            w_state_nxt = S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    w_load_bubble = 1'b1;
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    // EX payload and valid flag; unchanged when neither load is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
        end else if (w_load_bubble) begin
            r_ex    <= '0;
            r_valid <= 1'b0;
        end else if (w_load_id) begin
            r_ex    <= w_id;
            r_valid <= 1'b1;
        end
    end

`ifdef IDEX_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;
    logic        w_count_bubble;

    // Only RUN-state stall/flush bubbles are counted; HALT bubbles are not.
    assign w_count_bubble = en && (r_state == S_RUN) && (stall || flush);

    // Saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_count_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign ex_bubble_cnt = r_bubble_cnt;
`endif

    assign ex_op    = r_ex.op;
    assign ex_funct = r_ex.funct;
    assign ex_rs    = r_ex.rs;
    assign ex_rt    = r_ex.rt;
    assign ex_rd    = r_ex.rd;
    assign ex_shamt = r_ex.shamt;
    assign ex_pc    = r_ex.pc;
    assign ex_rd1   = r_ex.rd1;
    assign ex_rd2   = r_ex.rd2;
    assign ex_imm   = r_ex.imm;
    assign ex_fwd   = r_ex.fwd;
    assign ex_valid = r_valid;
    assign ex_halt  = (r_state == S_HALT);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: a behavioural reference model
// checked every negedge, plus hand-computed literal checks on directed vectors.
module tb_id_ex_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6 + 6 + 5 * 4 + DW * 4 + 6;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          stall;
    logic          flush;
    logic [5:0]    id_op, id_funct;
    logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
    logic [DW-1:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [5:0]    id_fwd;
    logic [5:0]    ex_op, ex_funct;
    logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [5:0]    ex_fwd;
    logic          ex_valid, ex_halt;
    logic [15:0]   ex_bubble_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    id_ex_stage_reg #(.DW(DW), .HALT_CODE(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .stall(stall), .flush(flush),
        .id_op(id_op), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_shamt(id_shamt), .id_pc(id_pc), .id_rd1(id_rd1),
        .id_rd2(id_rd2), .id_imm(id_imm), .id_fwd(id_fwd),
        .ex_op(ex_op), .ex_funct(ex_funct), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_pc(ex_pc), .ex_rd1(ex_rd1),
        .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_fwd(ex_fwd),
`ifdef IDEX_BUBBLE_CNT_EN
        .ex_bubble_cnt(ex_bubble_cnt),
`endif
        .ex_valid(ex_valid), .ex_halt(ex_halt)
    );

`ifndef IDEX_BUBBLE_CNT_EN
    assign ex_bubble_cnt = 16'h0;
`endif

    wire [AW-1:0] w_id_all = {id_op, id_funct, id_rs, id_rt, id_rd, id_shamt,
                              id_pc, id_rd1, id_rd2, id_imm, id_fwd};
    wire [AW-1:0] w_ex_all = {ex_op, ex_funct, ex_rs, ex_rt, ex_rd, ex_shamt,
                              ex_pc, ex_rd1, ex_rd2, ex_imm, ex_fwd};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what EX must contain after each edge.
    logic [AW-1:0] m_ex    = '0;
    logic          m_valid = 1'b0;
    logic          m_halt  = 1'b0;
    int            m_cnt   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = '0; m_valid = 1'b0; m_halt = 1'b0; m_cnt = 0;
        end else if (en) begin
            if (m_halt) begin
                m_ex = '0; m_valid = 1'b0;
            end else if (stall || flush) begin
                m_ex = '0; m_valid = 1'b0;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else begin
                m_ex = w_id_all; m_valid = 1'b1;
                if (id_op == 6'd0 && id_funct == 6'd12 && id_rd1 == 32'd10) m_halt = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("model_fields", w_ex_all, m_ex);
        check("model_valid", AW'(ex_valid), AW'(m_valid));
        check("model_halt", AW'(ex_halt), AW'(m_halt));
`ifdef IDEX_BUBBLE_CNT_EN
        check("model_cnt", AW'(ex_bubble_cnt), AW'(m_cnt));
`endif
    end

    task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [5:0] fwd);
        id_op = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = 5'd0;
        id_pc = 32'h0040_0000 + {27'd0, rd, 2'b00}; id_rd1 = rd1; id_rd2 = rd2;
        id_imm = 32'h0000_1234; id_fwd = fwd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'd0);
        tick(); tick();
        check("reset_fields", w_ex_all, '0);
        check("reset_valid", AW'(ex_valid), AW'(0));
        check("reset_halt", AW'(ex_halt), AW'(0));
        rst_n = 1'b1; en = 1'b1;

        // add $3,$1,$2
        tick();
        check("add_funct", AW'(ex_funct), AW'(6'h20));
        check("add_rd", AW'(ex_rd), AW'(3));
        check("add_rd1", AW'(ex_rd1), AW'(5));
        check("add_rd2", AW'(ex_rd2), AW'(7));
        check("add_valid", AW'(ex_valid), AW'(1));

        // load-use stall then release
        set_id(6'd0, 6'h22, 5'd3, 5'd4, 5'd5, 32'd12, 32'd9, 6'b100000);
        stall = 1'b1;
        tick();
        check("stall_fields", w_ex_all, '0);
        check("stall_valid", AW'(ex_valid), AW'(0));
        stall = 1'b0;
        tick();
        check("unstall_fwd", AW'(ex_fwd), AW'(6'b100000));
        check("unstall_rd", AW'(ex_rd), AW'(5));
        check("unstall_valid", AW'(ex_valid), AW'(1));

        // stall+flush together: one bubble, then frozen for 3 edges
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0; en = 1'b0;
        set_id(6'd0, 6'h20, 5'd6, 5'd7, 5'd8, 32'd1, 32'd2, 6'b000011);
        tick(); tick(); tick();
        check("frozen_valid", AW'(ex_valid), AW'(0));
        check("frozen_fields", w_ex_all, '0);
`ifdef IDEX_BUBBLE_CNT_EN
        check("cnt_two_bubbles", AW'(ex_bubble_cnt), AW'(2));
`endif
        en = 1'b1;

        // non-halting syscall
        set_id(6'd0, 6'h0c, 5'd2, 5'd0, 5'd0, 32'd1, 32'd0, 6'd0);
        tick();
        check("sys1_valid", AW'(ex_valid), AW'(1));
        check("sys1_halt", AW'(ex_halt), AW'(0));

        // halting syscall stalled, then flushed: no halt
        set_id(6'd0, 6'h0c, 5'd2, 5'd0, 5'd0, 32'd10, 32'd0, 6'd0);
        stall = 1'b1;
        tick();
        check("sys_stall_valid", AW'(ex_valid), AW'(0));
        check("sys_stall_halt", AW'(ex_halt), AW'(0));
        stall = 1'b0; flush = 1'b1;
        tick();
        check("sys_flush_halt", AW'(ex_halt), AW'(0));
        flush = 1'b0;

        // halting syscall
        tick();
        check("halt_valid", AW'(ex_valid), AW'(1));
        check("halt_halt", AW'(ex_halt), AW'(1));
        check("halt_funct", AW'(ex_funct), AW'(6'h0c));
        check("halt_rd1", AW'(ex_rd1), AW'(10));

        // valid adds on ID are ignored in HALT, stall/flush too
        set_id(6'd0, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b010000);
        for (int i = 0; i < 4; i++) begin
            stall = (i == 2); flush = (i == 3);
            tick();
            check("halted_valid", AW'(ex_valid), AW'(0));
            check("halted_halt", AW'(ex_halt), AW'(1));
            check("halted_fields", w_ex_all, '0);
        end
        stall = 1'b0; flush = 1'b0;
`ifdef IDEX_BUBBLE_CNT_EN
        check("cnt_no_halt_count", AW'(ex_bubble_cnt), AW'(4));
`endif

        // async reset clears with no clock edge
        rst_n = 1'b0;
        #1;
        check("async_halt", AW'(ex_halt), AW'(0));
        check("async_valid", AW'(ex_valid), AW'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_valid", AW'(ex_valid), AW'(1));
        check("post_reset_rd", AW'(ex_rd), AW'(3));
        check("post_reset_fwd", AW'(ex_fwd), AW'(6'b010000));

        // mixed vectors checked by the model
        for (int i = 0; i < 60; i++) begin
            set_id(6'($urandom_range(0, 3)), (i % 7 == 0) ? 6'h0c : 6'($urandom),
                   5'($urandom), 5'($urandom), 5'($urandom),
                   (i % 11 == 0) ? 32'd10 : $urandom, $urandom, 6'($urandom));
            id_shamt = 5'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 4) == 0);
            tick();
        end

`ifdef IDEX_BUBBLE_CNT_EN
        // counter saturation
        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        tick();
        rst_n = 1'b1; stall = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        check("cnt_saturated", AW'(ex_bubble_cnt), AW'(16'hFFFF));
        en = 1'b0;
        tick();
        check("cnt_hold", AW'(ex_bubble_cnt), AW'(16'hFFFF));
        rst_n = 1'b0;
        #1;
        check("cnt_async_clear", AW'(ex_bubble_cnt), AW'(0));
        stall = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
